fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the five-stage pipeline, directly upstream of decode. It owns the program counter and issues word addresses to the synchronous instruction ROM (one-cycle read latency). It delivers `{pc, instruction}` on the 62-bit IF→ID bus with a valid/ready handshake. It applies branch/jump redirects from execute and exception-vector redirects from the CP0 logic, and flags fetches outside the ROM window as fetch exceptions.

## Interface
- `RESET_PC`, 30'h0, word address fetched first after reset
- `EXC_PC`, 30'h0000_0060, word address of exception handler (byte 0x180)
- `ROM_AW`, 8, ROM word-address width
- `clk`  in  1  clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-low reset
- `jump`  in  1  redirect request from execute
- `jump_addr`  in  30  redirect target, word address
- `exc_flush`  in  1  exception redirect from CP0 logic; overrides `jump`
- `next_ready`  in  1  decode accepts the IF→ID entry this cycle
- `rom_data`  in  32  ROM read data for the address issued the previous cycle
- `rom_en`  out  1  ROM read enable
- `rom_addr`  out  ROM_AW  ROM word address, equal to `nextPC[ROM_AW-1:0]`
- `nextPC`  out  30  address being issued this cycle
- `IF_ID_BUS`  out  62  `{pc[29:0], ins[31:0]}`
- `valid`  out  1  IF_ID_BUS holds a valid entry
- `fetch_exc`  out  1  current entry's pc is outside the ROM window

## Operation
- States: IDLE (reset), WAIT (one request in flight), HOLD (response parked in skid register, no request in flight).
- Registers: `req_pc`, output entry `{out_pc, out_ins, out_exc}` with `valid`, and skid entry `{skid_pc, skid_ins, skid_exc}`.
- `fire = valid & next_ready`. `room = ~valid | next_ready`.
- Redirect: `redir = exc_flush | jump`. The target is `EXC_PC` if `exc_flush`, else `jump_addr`. A redirect is honoured in every non-reset state. In that cycle the unit clears `valid`, discards the skid entry and the in-flight response, issues the target (`rom_en=1`, `nextPC`=target, combinationally in the same cycle), sets `req_pc`=target, and goes to WAIT. `fire` in a redirect cycle still counts as an accept by decode.
- IDLE: issue `RESET_PC`, then go to WAIT.
- WAIT, no redirect, `room`: load the output entry from `{req_pc, rom_data}`, set `valid=1`, issue `req_pc+1`, and stay in WAIT.
- WAIT, no redirect, `~room`: load the skid entry from `{req_pc, rom_data}`, set `rom_en=0`, hold `nextPC` at `req_pc`, and go to HOLD.
- HOLD, no redirect, `next_ready`: move the skid entry to the output, issue `skid_pc+1`, and go to WAIT. If `~next_ready`, nothing changes.
- Out-of-window: `exc = |pc[29:ROM_AW]`. When an entry is captured with `exc=1`, `ins` is forced to 32'h0 and `fetch_exc=1`. Fetching continues sequentially; the CP0 logic is expected to flush.
- PC arithmetic is 30-bit modulo; 30'h3FFF_FFFF+1 wraps to 0.
- `fetch_exc` is qualified by `valid` (0 when `valid=0`).

## Timing
- During reset (`reset=0` at an edge): state=IDLE, `valid=0`, `fetch_exc=0`, `IF_ID_BUS=0`, skid cleared, `req_pc=RESET_PC`. While `reset=0`, `rom_en=0` and `nextPC=0`.
- Fetch latency: an address issued in cycle t appears on IF_ID_BUS with `valid=1` in cycle t+2 (ROM read at edge t+1, capture at edge t+2).
- Steady-state throughput: one instruction per cycle while `next_ready=1`.
- Redirect penalty: the target appears at cycle t+2 after a redirect asserted in cycle t. Output is invalid at t+1.
- Stall: at most one response is parked. No address is issued in HOLD. No entry is lost or duplicated.
- `exc_flush` and `jump` together: `EXC_PC` wins.
- Reset asserted mid-stream (WAIT or HOLD): at the next edge all state returns to the reset values. In-flight data is ignored.

## Test plan
- Reset release, `next_ready=1`, ROM[i]=i: `nextPC` = 0,1,2…. Cycle 2 after release shows `{0, 32'h0}` valid, then `{1,1}`, `{2,2}` back-to-back.
- Stall: drop `next_ready` for 3 cycles after pc 4 is presented. Pc 4 is held, 5 is parked in skid, and `rom_en=0`. On release, 4, 5, 6 are delivered in consecutive cycles with none skipped.
- `jump=1`, `jump_addr=30'h20` while streaming: next cycle `valid=0`. Two cycles later `{30'h20, ROM[0x20]}` is delivered. The old sequential entries never appear.
- `jump` and `exc_flush` in the same cycle as a HOLD stall: skid is discarded and `{30'h60, ROM[0x60]}` appears two cycles later.
- `jump_addr=30'h100` with `ROM_AW=8`: the entry has pc 30'h100, ins 0, and `fetch_exc=1`. The following pc 30'h101 is also flagged.
- Assert `reset=0` for one cycle while in HOLD: `valid=0` and `fetch_exc=0`. The fetch restarts at `RESET_PC` with the first entry two cycles after release.

Source files
------------

// File: rtl/fetch_unit_if.sv
// IF->ID handshake bundle: {pc, ins} entry, valid/ready, fetch exception.
// The fetch stage drives through master, decode consumes through slave.
interface fetch_unit_if;
  logic [61:0] IF_ID_BUS;
  logic        valid;
  logic        fetch_exc;
  logic        next_ready;

  modport master (
    output IF_ID_BUS,
    output valid,
    output fetch_exc,
    input  next_ready
  );

  modport slave (
    input  IF_ID_BUS,
    input  valid,
    input  fetch_exc,
    output next_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, drives the synchronous ROM and feeds
// decode through a one-entry skid so back-pressure never drops a word.
module fetch_unit #(
  parameter logic [29:0] RESET_PC = 30'h0,
  parameter logic [29:0] EXC_PC   = 30'h0000_0060,
  parameter int unsigned ROM_AW   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              jump,
  input  logic [29:0]       jump_addr,
  input  logic              exc_flush,
  input  logic [31:0]       rom_data,
  output logic              rom_en,
  output logic [ROM_AW-1:0] rom_addr,
  output logic [29:0]       nextPC,
  fetch_unit_if.master      ifid
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_HOLD
  } state_t;

  typedef struct packed {
    logic [29:0] pc;
    logic [31:0] ins;
    logic        exc;
  } entry_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [29:0] r_req_pc;
  entry_t      r_out;
  entry_t      r_skid;
  logic        r_valid;

  logic        w_idle;
  logic        w_wait;
  logic        w_hold;
  logic        w_room;
  logic        w_redir;
  logic [29:0] w_target;
  logic        w_exc;
  entry_t      w_cap;
  logic        w_ld_out;
  logic        w_ld_skid;
  logic        w_sel_skid;
  logic        w_clr;

  assign w_idle   = (r_state == S_IDLE);
  assign w_wait   = (r_state == S_WAIT);
  assign w_hold   = (r_state == S_HOLD);
  assign w_room   = ~r_valid | ifid.next_ready;
  assign w_redir  = (exc_flush | jump) & ~w_idle;
  assign w_target = exc_flush ? EXC_PC : jump_addr;

  // The ROM word returned now belongs to the address issued last cycle.
  assign w_exc = |r_req_pc[29:ROM_AW];
  assign w_cap = {r_req_pc, (w_exc ? 32'h0 : rom_data), w_exc};

  assign rom_addr = nextPC[ROM_AW-1:0];

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: w_state_nxt = S_WAIT;
      S_WAIT:
        if (!w_redir && !w_room)
          w_state_nxt = S_HOLD;
      S_HOLD:
        if (w_redir || ifid.next_ready)
          w_state_nxt = S_WAIT;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    rom_en     = 1'b0;
    nextPC     = r_req_pc;
    w_ld_out   = 1'b0;
    w_ld_skid  = 1'b0;
    w_sel_skid = 1'b0;
    w_clr      = 1'b0;
    if (!reset) begin
      nextPC = '0;
    end else begin
      unique case (1'b1)
        w_redir: begin
          rom_en = 1'b1;
          nextPC = w_target;
          w_clr  = 1'b1;
        end
        w_idle: begin
          rom_en = 1'b1;
          nextPC = RESET_PC;
        end
        (w_wait & w_room & ~w_redir): begin
          rom_en   = 1'b1;
          nextPC   = r_req_pc + 30'd1;
          w_ld_out = 1'b1;
        end
        (w_wait & ~w_room & ~w_redir): begin
          w_ld_skid = 1'b1;
        end
        (w_hold & ifid.next_ready & ~w_redir): begin
          rom_en     = 1'b1;
          nextPC     = r_skid.pc + 30'd1;
          w_ld_out   = 1'b1;
          w_sel_skid = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_req_pc <= RESET_PC;
      r_out    <= '0;
      r_skid   <= '0;
      r_valid  <= 1'b0;
    end else begin
      if (rom_en) r_req_pc <= nextPC;
      if (w_clr) begin
        r_valid <= 1'b0;
        r_skid  <= '0;
      end else begin
        if (w_ld_out) begin
          r_valid <= 1'b1;
          r_out   <= w_sel_skid ? r_skid : w_cap;
        end
        if (w_ld_skid) r_skid <= w_cap;
      end
    end
  end

  assign ifid.IF_ID_BUS = {r_out.pc, r_out.ins};
  assign ifid.valid     = r_valid;
  assign ifid.fetch_exc = r_valid & r_out.exc;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: cycle table, corner sequences, random stalls and
// redirects, with a queue scoreboard checking every accepted entry.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        jump = 1'b0;
  logic        exc_flush = 1'b0;
  logic [29:0] jump_addr = '0;
  logic [31:0] rom_data = '0;
  logic        rom_en;
  logic [7:0]  rom_addr;
  logic [29:0] nextPC;
  logic        nr = 1'b0;

  fetch_unit_if ifid ();
  assign ifid.next_ready = nr;

  fetch_unit #(
    .RESET_PC(30'h0),
    .EXC_PC  (30'h60),
    .ROM_AW  (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .jump     (jump),
    .jump_addr(jump_addr),
    .exc_flush(exc_flush),
    .rom_data (rom_data),
    .rom_en   (rom_en),
    .rom_addr (rom_addr),
    .nextPC   (nextPC),
    .ifid     (ifid)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rom_en) rom_data <= {24'h0, rom_addr};

  int n_chk = 0;
  int n_fail = 0;

  function automatic logic [31:0] exp_ins(input logic [29:0] pc);
    return (|pc[29:8]) ? 32'h0 : {24'h0, pc[7:0]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [29:0] pc;
    logic [31:0] ins;
    logic        exc;
  } sb_t;

  sb_t         sbq[$];
  logic [29:0] sb_last;

  function automatic sb_t mk(input logic [29:0] pc);
    sb_t e;
    e.pc  = pc;
    e.ins = exp_ins(pc);
    e.exc = |pc[29:8];
    return e;
  endfunction

  task automatic sb_reset(input logic [29:0] tgt);
    sbq.delete();
    for (int k = 0; k < 16; k++) sbq.push_back(mk(tgt + 30'(k)));
    sb_last = tgt + 30'd15;
  endtask

  always @(negedge clk) begin
    if (reset && ifid.valid && ifid.next_ready) begin
      if (sbq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_empty: got entry %h expected none", ifid.IF_ID_BUS);
      end else begin
        sb_t e;
        e = sbq.pop_front();
        chk("sb_entry", {1'b0, ifid.IF_ID_BUS, ifid.fetch_exc},
            {1'b0, e.pc, e.ins, e.exc});
        sb_last = sb_last + 30'd1;
        sbq.push_back(mk(sb_last));
      end
    end
  end

  typedef struct {
    logic        nr;
    logic        jmp;
    logic        exf;
    logic [29:0] ja;
    logic        ev;
    logic [29:0] epc;
    logic        ee;
    logic        een;
    logic [29:0] enp;
  } vec_t;

  localparam int NV = 28;
  vec_t tbl[NV];

  task automatic setv(input int i, input logic n, input logic j,
                      input logic x, input logic [29:0] a,
                      input logic v, input logic [29:0] p,
                      input logic e, input logic en,
                      input logic [29:0] np);
    tbl[i] = '{n, j, x, a, v, p, e, en, np};
  endtask

  task automatic check_row(input vec_t r);
    chk("valid", 64'(ifid.valid), 64'(r.ev));
    chk("fetch_exc", 64'(ifid.fetch_exc), 64'(r.ev & r.ee));
    chk("rom_en", 64'(rom_en), 64'(r.een));
    chk("nextPC", 64'(nextPC), 64'(r.enp));
    chk("rom_addr", 64'(rom_addr), 64'(r.enp[7:0]));
    if (r.ev)
      chk("bus", 64'(ifid.IF_ID_BUS), 64'({r.epc, exp_ins(r.epc)}));
  endtask

  initial begin
    setv( 0, 1, 0, 0, 30'h0,   0, 30'h0,   0, 1, 30'h0);
    setv( 1, 1, 0, 0, 30'h0,   0, 30'h0,   0, 1, 30'h1);
    setv( 2, 1, 0, 0, 30'h0,   1, 30'h0,   0, 1, 30'h2);
    setv( 3, 1, 0, 0, 30'h0,   1, 30'h1,   0, 1, 30'h3);
    setv( 4, 1, 0, 0, 30'h0,   1, 30'h2,   0, 1, 30'h4);
    setv( 5, 1, 0, 0, 30'h0,   1, 30'h3,   0, 1, 30'h5);
    setv( 6, 0, 0, 0, 30'h0,   1, 30'h4,   0, 0, 30'h5);
    setv( 7, 0, 0, 0, 30'h0,   1, 30'h4,   0, 0, 30'h5);
    setv( 8, 0, 0, 0, 30'h0,   1, 30'h4,   0, 0, 30'h5);
    setv( 9, 1, 0, 0, 30'h0,   1, 30'h4,   0, 1, 30'h6);
    setv(10, 1, 0, 0, 30'h0,   1, 30'h5,   0, 1, 30'h7);
    setv(11, 1, 0, 0, 30'h0,   1, 30'h6,   0, 1, 30'h8);
    setv(12, 1, 1, 0, 30'h20,  1, 30'h7,   0, 1, 30'h20);
    setv(13, 1, 0, 0, 30'h0,   0, 30'h0,   0, 1, 30'h21);
    setv(14, 1, 0, 0, 30'h0,   1, 30'h20,  0, 1, 30'h22);
    setv(15, 0, 0, 0, 30'h0,   1, 30'h21,  0, 0, 30'h22);
    setv(16, 0, 1, 1, 30'h33,  1, 30'h21,  0, 1, 30'h60);
    setv(17, 1, 0, 0, 30'h0,   0, 30'h0,   0, 1, 30'h61);
    setv(18, 1, 0, 0, 30'h0,   1, 30'h60,  0, 1, 30'h62);
    setv(19, 1, 1, 0, 30'h100, 1, 30'h61,  0, 1, 30'h100);
    setv(20, 1, 0, 0, 30'h0,   0, 30'h0,   0, 1, 30'h101);
    setv(21, 1, 0, 0, 30'h0,   1, 30'h100, 1, 1, 30'h102);
    setv(22, 1, 0, 0, 30'h0,   1, 30'h101, 1, 1, 30'h103);
    setv(23, 1, 1, 0, 30'h3FFF_FFFF, 1, 30'h102, 1, 1, 30'h3FFF_FFFF);
    setv(24, 1, 0, 0, 30'h0,   0, 30'h0,   0, 1, 30'h0);
    setv(25, 1, 0, 0, 30'h0,   1, 30'h3FFF_FFFF, 1, 1, 30'h1);
    setv(26, 1, 0, 0, 30'h0,   1, 30'h0,   0, 1, 30'h2);
    setv(27, 1, 0, 0, 30'h0,   1, 30'h1,   0, 1, 30'h3);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(ifid.valid), 64'd0);
    chk("rst_fexc", 64'(ifid.fetch_exc), 64'd0);
    chk("rst_bus", 64'(ifid.IF_ID_BUS), 64'd0);
    chk("rst_rom_en", 64'(rom_en), 64'd0);
    chk("rst_nextPC", 64'(nextPC), 64'd0);

    @(posedge clk); #1;
    reset = 1'b1;
    sb_reset(30'h0);
    for (int i = 0; i < NV; i++) begin
      nr        = tbl[i].nr;
      jump      = tbl[i].jmp;
      exc_flush = tbl[i].exf;
      jump_addr = tbl[i].ja;
      @(negedge clk);
      check_row(tbl[i]);
      @(posedge clk);
      if (tbl[i].exf)      sb_reset(30'h60);
      else if (tbl[i].jmp) sb_reset(tbl[i].ja);
      #1;
    end

    jump = 1'b0;
    exc_flush = 1'b0;
    nr = 1'b0;
    @(negedge clk);
    chk("stall_rom_en", 64'(rom_en), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("hold_rom_en", 64'(rom_en), 64'd0);
    chk("hold_nextPC", 64'(nextPC), 64'h3);
    chk("hold_bus", 64'(ifid.IF_ID_BUS), 64'({30'h2, 32'h2}));
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rsthold_rom_en", 64'(rom_en), 64'd0);
    chk("rsthold_nextPC", 64'(nextPC), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    nr = 1'b1;
    sb_reset(30'h0);
    @(negedge clk);
    chk("rel_valid", 64'(ifid.valid), 64'd0);
    chk("rel_fexc", 64'(ifid.fetch_exc), 64'd0);
    chk("rel_bus", 64'(ifid.IF_ID_BUS), 64'd0);
    chk("rel_nextPC", 64'(nextPC), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rel1_valid", 64'(ifid.valid), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rel2_valid", 64'(ifid.valid), 64'd1);
    chk("rel2_bus", 64'(ifid.IF_ID_BUS), 64'd0);

    for (int c = 0; c < 400; c++) begin
      logic [29:0] tgt;
      logic        rd;
      @(posedge clk); #1;
      nr        = ($urandom_range(0, 3) != 0);
      exc_flush = ($urandom_range(0, 39) == 0);
      jump      = ($urandom_range(0, 14) == 0);
      jump_addr = 30'($urandom_range(0, 300));
      rd  = jump | exc_flush;
      tgt = exc_flush ? 30'h60 : jump_addr;
      @(posedge clk);
      if (rd) sb_reset(tgt);
      #1;
      jump      = 1'b0;
      exc_flush = 1'b0;
    end

    @(posedge clk); #1;
    nr = 1'b0;
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
